// File: rtl/tlc_ctrl.sv
// Four-phase traffic light controller: NS green/yellow then EW green/yellow, each timed in clk cycles.
// Optional lamp outputs ns_lamp/ew_lamp ({red,yellow,green}) are built when TLC_LIGHTS_EN is defined.
//
// state     | meaning
// NS_GREEN  | north-south go, east-west stopped
// NS_YELLOW | north-south clearing
// EW_GREEN  | east-west go, north-south stopped
// EW_YELLOW | east-west clearing
module tlc_ctrl #(
  parameter int GREEN_TIME  = 10,
  parameter int YELLOW_TIME = 3
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] count,
  output logic [1:0] ps_state
`ifdef TLC_LIGHTS_EN
  ,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp
`endif
);

  typedef enum logic [1:0] {
    NS_GREEN  = 2'b00,
    NS_YELLOW = 2'b01,
    EW_GREEN  = 2'b10,
    EW_YELLOW = 2'b11
  } state_t;

  // Dwell times are clamped to 1..16 so the terminal count always fits the 4-bit counter.
  localparam int G_T = (GREEN_TIME < 1) ? 1 : ((GREEN_TIME > 16) ? 16 : GREEN_TIME);
  localparam int Y_T = (YELLOW_TIME < 1) ? 1 : ((YELLOW_TIME > 16) ? 16 : YELLOW_TIME);
  localparam logic [3:0] G_LAST = 4'(G_T - 1);
  localparam logic [3:0] Y_LAST = 4'(Y_T - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] last;

  // Every 2-bit code is a legal state, so the sequence is a plain wrap-around increment.
  assign state_next = state_t'(state + 2'b01);
  assign last       = state[0] ? Y_LAST : G_LAST;
  assign ps_state   = state;

`ifdef TLC_LIGHTS_EN
  function automatic logic [2:0] ns_of(state_t s);
    case (s)
      NS_GREEN:  ns_of = 3'b001;
      NS_YELLOW: ns_of = 3'b010;
      default:   ns_of = 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] ew_of(state_t s);
    case (s)
      EW_GREEN:  ew_of = 3'b001;
      EW_YELLOW: ew_of = 3'b010;
      default:   ew_of = 3'b100;
    endcase
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NS_GREEN;
      count <= 4'd0;
`ifdef TLC_LIGHTS_EN
      ns_lamp <= 3'b001;
      ew_lamp <= 3'b100;
`endif
    end else if (count >= last) begin
      state <= state_next;
      count <= 4'd0;
`ifdef TLC_LIGHTS_EN
      ns_lamp <= ns_of(state_next);
      ew_lamp <= ew_of(state_next);
`endif
    end else begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: tb/tb_tlc_ctrl.sv
// Bench for tlc_ctrl: default, boundary (16/1) and clamped (0/20) instances checked against a
// position-in-period model. Lamp checks are included when TLC_LIGHTS_EN is defined.
module tb_tlc_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic [3:0] count_a, count_b, count_c;
  logic [1:0] st_a, st_b, st_c;
`ifdef TLC_LIGHTS_EN
  logic [2:0] ns_a, ew_a, ns_b, ew_b, ns_c, ew_c;
`endif

  tlc_ctrl dut_a (.clk(clk), .rst(rst), .count(count_a), .ps_state(st_a)
`ifdef TLC_LIGHTS_EN
    , .ns_lamp(ns_a), .ew_lamp(ew_a)
`endif
  );
  tlc_ctrl #(.GREEN_TIME(16), .YELLOW_TIME(1)) dut_b (.clk(clk), .rst(rst), .count(count_b), .ps_state(st_b)
`ifdef TLC_LIGHTS_EN
    , .ns_lamp(ns_b), .ew_lamp(ew_b)
`endif
  );
  tlc_ctrl #(.GREEN_TIME(0), .YELLOW_TIME(20)) dut_c (.clk(clk), .rst(rst), .count(count_c), .ps_state(st_c)
`ifdef TLC_LIGHTS_EN
    , .ns_lamp(ns_c), .ew_lamp(ew_c)
`endif
  );

  int n;       // edges since the last reset edge
  int checks;
  int fails;

  function automatic int clampt(input int v);
    clampt = (v < 1) ? 1 : ((v > 16) ? 16 : v);
  endfunction

  // Expected state/count after n edges: locate n within the period of four dwell intervals.
  task automatic model(input int edges, input int g, input int y, output int st, output int cnt);
    int gc, yc, rem, d;
    bit done;
    gc = clampt(g);
    yc = clampt(y);
    rem = edges % (2 * (gc + yc));
    st = 0;
    cnt = 0;
    done = 0;
    for (int i = 0; i < 4; i++) begin
      d = (i % 2 == 0) ? gc : yc;
      if (!done) begin
        if (rem < d) begin
          st = i;
          cnt = rem;
          done = 1;
        end else begin
          rem -= d;
        end
      end
    end
  endtask

  task automatic step(input logic r);
    @(negedge clk);
    rst = r;
    @(posedge clk);
    #1;
    n = r ? 0 : n + 1;
  endtask

  task automatic test_reset();
    step(1'b1);
    checks++;
    if (st_a !== 2'b00 || count_a !== 4'd0) begin
      fails++;
      $display("FAIL reset_state: got st=%b cnt=%0d expected st=00 cnt=0", st_a, count_a);
    end
`ifdef TLC_LIGHTS_EN
    checks++;
    if (ns_a !== 3'b001 || ew_a !== 3'b100) begin
      fails++;
      $display("FAIL reset_lamps: got ns=%b ew=%b expected ns=001 ew=100", ns_a, ew_a);
    end
`endif
    step(1'b0);
    checks++;
    if (st_a !== 2'b00 || count_a !== 4'd1) begin
      fails++;
      $display("FAIL first_edge: got st=%b cnt=%0d expected st=00 cnt=1", st_a, count_a);
    end
    repeat (8) step(1'b0);
    checks++;
    if (st_a !== 2'b00 || count_a !== 4'd9) begin
      fails++;
      $display("FAIL nine_edges: got st=%b cnt=%0d expected st=00 cnt=9", st_a, count_a);
    end
  endtask

  task automatic test_full_cycle();
    int edge_at[4] = '{10, 13, 23, 26};
    logic [1:0] st_at[4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    int k;
    k = 0;
    step(1'b1);
    for (int e = 1; e <= 26; e++) begin
      step(1'b0);
      if (k < 4 && e == edge_at[k]) begin
        checks++;
        if (st_a !== st_at[k] || count_a !== 4'd0) begin
          fails++;
          $display("FAIL full_cycle edge %0d: got st=%b cnt=%0d expected st=%b cnt=0",
                   e, st_a, count_a, st_at[k]);
        end
`ifdef TLC_LIGHTS_EN
        if (k == 0) begin
          checks++;
          if (ns_a !== 3'b010 || ew_a !== 3'b100) begin
            fails++;
            $display("FAIL lamps_ns_yellow: got ns=%b ew=%b expected ns=010 ew=100", ns_a, ew_a);
          end
        end
`endif
        k++;
      end
    end
  endtask

  task automatic test_yellow_dwell();
    logic [1:0] exp_st[4] = '{2'b01, 2'b01, 2'b01, 2'b10};
    logic [3:0] exp_c[4]  = '{4'd0, 4'd1, 4'd2, 4'd0};
    step(1'b1);
    repeat (9) step(1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      checks++;
      if (st_a !== exp_st[i] || count_a !== exp_c[i]) begin
        fails++;
        $display("FAIL yellow_dwell[%0d]: got st=%b cnt=%0d expected st=%b cnt=%0d",
                 i, st_a, count_a, exp_st[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    step(1'b1);
    repeat (17) step(1'b0);
    checks++;
    if (st_a !== 2'b10 || count_a !== 4'd4) begin
      fails++;
      $display("FAIL mid_reset_pre: got st=%b cnt=%0d expected st=10 cnt=4", st_a, count_a);
    end
    step(1'b1);
    checks++;
    if (st_a !== 2'b00 || count_a !== 4'd0) begin
      fails++;
      $display("FAIL mid_reset: got st=%b cnt=%0d expected st=00 cnt=0", st_a, count_a);
    end
    step(1'b0);
    checks++;
    if (st_a !== 2'b00 || count_a !== 4'd1) begin
      fails++;
      $display("FAIL mid_reset_restart: got st=%b cnt=%0d expected st=00 cnt=1", st_a, count_a);
    end
  endtask

  task automatic test_boundary();
    int max_green, yellow_cycles, ms, mc;
    max_green = 0;
    yellow_cycles = 0;
    step(1'b1);
    for (int e = 1; e <= 34; e++) begin
      step(1'b0);
      model(n, 16, 1, ms, mc);
      checks++;
      if (int'(st_b) !== ms || int'(count_b) !== mc) begin
        fails++;
        $display("FAIL boundary edge %0d: got st=%b cnt=%0d expected st=%0d cnt=%0d",
                 e, st_b, count_b, ms, mc);
      end
      if (st_b == 2'b00 && int'(count_b) > max_green) max_green = int'(count_b);
      if (st_b == 2'b01) yellow_cycles++;
    end
    checks++;
    if (max_green !== 15 || yellow_cycles !== 1 || st_b !== 2'b00 || count_b !== 4'd0) begin
      fails++;
      $display("FAIL boundary_summary: got max_green=%0d ns_yellow=%0d end st=%b cnt=%0d expected 15 1 00 0",
               max_green, yellow_cycles, st_b, count_b);
    end
  endtask

  task automatic test_clamp();
    step(1'b1);
    step(1'b0);
    checks++;
    if (st_c !== 2'b01 || count_c !== 4'd0) begin
      fails++;
      $display("FAIL clamp_green0: got st=%b cnt=%0d expected st=01 cnt=0", st_c, count_c);
    end
    repeat (15) step(1'b0);
    checks++;
    if (st_c !== 2'b01 || count_c !== 4'd15) begin
      fails++;
      $display("FAIL clamp_yellow16: got st=%b cnt=%0d expected st=01 cnt=15", st_c, count_c);
    end
    step(1'b0);
    checks++;
    if (st_c !== 2'b10 || count_c !== 4'd0) begin
      fails++;
      $display("FAIL clamp_advance: got st=%b cnt=%0d expected st=10 cnt=0", st_c, count_c);
    end
  endtask

  task automatic test_random();
    int ms, mc;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
      model(n, 10, 3, ms, mc);
      checks++;
      if (int'(st_a) !== ms || int'(count_a) !== mc) begin
        fails++;
        $display("FAIL random_a n=%0d: got st=%b cnt=%0d expected st=%0d cnt=%0d", n, st_a, count_a, ms, mc);
      end
`ifdef TLC_LIGHTS_EN
      checks++;
      if (ns_a !== ((ms == 0) ? 3'b001 : (ms == 1) ? 3'b010 : 3'b100) ||
          ew_a !== ((ms == 2) ? 3'b001 : (ms == 3) ? 3'b010 : 3'b100)) begin
        fails++;
        $display("FAIL random_lamps n=%0d: got ns=%b ew=%b for state %0d", n, ns_a, ew_a, ms);
      end
`endif
      model(n, 16, 1, ms, mc);
      checks++;
      if (int'(st_b) !== ms || int'(count_b) !== mc) begin
        fails++;
        $display("FAIL random_b n=%0d: got st=%b cnt=%0d expected st=%0d cnt=%0d", n, st_b, count_b, ms, mc);
      end
      model(n, 0, 20, ms, mc);
      checks++;
      if (int'(st_c) !== ms || int'(count_c) !== mc) begin
        fails++;
        $display("FAIL random_c n=%0d: got st=%b cnt=%0d expected st=%0d cnt=%0d", n, st_c, count_c, ms, mc);
      end
    end
  endtask

  initial begin
    n = 0;
    checks = 0;
    fails = 0;
    test_reset();
    test_full_cycle();
    test_yellow_dwell();
    test_mid_reset();
    test_boundary();
    test_clamp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/tlc_ctrl.md
TLC_CTRL -- requirements
Module: tlc_ctrl

Interface
REQ-001 The block SHALL have parameter GREEN_TIME, default 10, meaning cycles spent in each green state.
REQ-002 The block SHALL have parameter YELLOW_TIME, default 3, meaning cycles spent in each yellow state.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port count, output, 4 bits: cycles elapsed in the present state, starting from 0.
REQ-006 The block SHALL have port ps_state, output, 2 bits: present state code.
REQ-007 The port order SHALL be clk, rst, count, ps_state, so that positional instantiation with four connections binds correctly.
REQ-008 Any macro-enabled ports SHALL follow ps_state.

Function
REQ-009 State encoding SHALL be: 2'b00 NS_GREEN; 2'b01 NS_YELLOW; 2'b10 EW_GREEN; 2'b11 EW_YELLOW.
REQ-010 The state sequence SHALL be NS_GREEN -> NS_YELLOW -> EW_GREEN -> EW_YELLOW -> NS_GREEN, repeating indefinitely.
REQ-011 The state duration T SHALL be GREEN_TIME in the green states and YELLOW_TIME in the yellow states.
REQ-012 On each rising clk edge with rst=0 and count < T-1, the block SHALL increment count by 1 and hold the state.
REQ-013 On each rising clk edge with rst=0 and count == T-1, the block SHALL advance to the next state and set count to 0 on the same edge.
REQ-014 The total period SHALL be 2*(GREEN_TIME+YELLOW_TIME) cycles; with defaults this is 26.
REQ-015 Effective T SHALL be clamped to the range 1..16; a parameter value of 0 SHALL behave as 1, and a value above 16 SHALL behave as 16.
REQ-016 When T=1, the state SHALL advance every cycle and count SHALL stay at 0.
REQ-017 When T=16, count SHALL reach 15 without wrapping before the state advances.
REQ-018 count and ps_state SHALL be registered outputs with no combinational path from rst.
REQ-019 The state register SHALL have no illegal states: all four 2-bit codes are valid.

Reset
REQ-020 While rst=1 at a rising clk edge, the block SHALL set ps_state=2'b00 and count=4'd0.
REQ-021 rst SHALL take priority over every state transition.
REQ-022 Asserting rst mid-cycle of any state SHALL restart the sequence at NS_GREEN, count 0, on the next edge.
REQ-023 After rst is released, the first non-reset edge SHALL produce count=1 with ps_state=00.

Configuration
REQ-024 The block SHALL support a macro TLC_LIGHTS_EN.
REQ-025 When TLC_LIGHTS_EN is defined, the block SHALL add registered outputs ns_lamp[2:0] and ew_lamp[2:0], encoded {red,yellow,green}.
REQ-026 With TLC_LIGHTS_EN defined, the lamp outputs SHALL be: NS_GREEN ns=001, ew=100; NS_YELLOW ns=010, ew=100; EW_GREEN ns=100, ew=001; EW_YELLOW ns=100, ew=010.
REQ-027 With TLC_LIGHTS_EN defined, both lamp outputs SHALL reset to the NS_GREEN values and SHALL update on the same edge as ps_state.
REQ-028 When TLC_LIGHTS_EN is not defined, the lamp ports and logic SHALL be absent, and count/ps_state behaviour SHALL be identical to the macro-defined build.

Verification
REQ-029 Reset: rst=1 for 1 edge, then rst=0 with 20 ns clock -> ps_state=00, count=0; after 9 edges count=9, ps_state=00.
REQ-030 Full cycle with defaults: edges 10, 13, 23 and 26 after reset release -> ps_state 01, 10, 11, 00 respectively, with count=0 at each transition.
REQ-031 Yellow dwell: in NS_YELLOW, count SHALL take the values 0, 1, 2, then ps_state becomes 10.
REQ-032 Mid-state reset: assert rst for 1 edge while ps_state=10 and count=4 -> ps_state=00, count=0 on that edge; the sequence restarts.
REQ-033 Boundaries: GREEN_TIME=16, YELLOW_TIME=1 -> count reaches 15 in green, yellow lasts exactly 1 cycle with count=0, and the period is 34 cycles.
REQ-034 Macro build: with TLC_LIGHTS_EN defined, at the edge where ps_state becomes 01 -> ns_lamp=010 and ew_lamp=100.
